// File: rtl/bus_pkg.sv
// Shared constants and the request payload type for the data-bus arbiter.
// Pure definitions: no latency, no flow control.
package bus_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int BE_W   = 4;

  localparam logic MST_CORE = 1'b0;
  localparam logic MST_DMA  = 1'b1;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/data_bus_arbiter_id_fifo.sv
// In-order FIFO of 1-bit master IDs; dout/full/empty/count are registered state.
// Latency: push visible at dout next cycle; backpressure: push ignored when full, pop ignored when empty.
module id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         din_i,
  output logic                         dout_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths behave.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  always_comb begin
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q] = din_i;
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master OBI arbiter: 0-cycle grant and response routing, in-order ID tracking.
// Backpressure: a stalled request is held until granted; new requests block while MAX_OUTSTANDING are in flight.
module data_bus_arbiter
  import bus_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int PRIO_MODE       = PRIO_RR
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [BE_W-1:0]   m0_be_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [BE_W-1:0]   m1_be_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              s_req_o,
  output logic              s_we_o,
  output logic [BE_W-1:0]   s_be_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_wdata_o,
  input  logic              s_gnt_i,
  input  logic              s_rvalid_i,
  input  logic [DATA_W-1:0] s_rdata_i,
  output logic              err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  req_t             m0_bus, m1_bus, s_bus;
  logic [1:0]       req;
  logic [0:0]       hold_q, hold_d;
  logic             sel, sel_q, sel_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic             hold_act, s_req, accept, rsp_vld, stray;
  logic             head, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_cnt;

  assign m0_bus = '{we: m0_we_i, be: m0_be_i, addr: m0_addr_i, wdata: m0_wdata_i};
  assign m1_bus = '{we: m1_we_i, be: m1_be_i, addr: m1_addr_i, wdata: m1_wdata_i};
  assign req    = {m1_req_i, m0_req_i};

  always_comb begin
    // A held master that drops req forfeits its hold; arbitrate afresh.
    hold_act = (hold_q == ST_HOLD) & req[sel_q];
    if (hold_act)           sel = sel_q;
    else if (req == 2'b11)  sel = (PRIO_MODE == PRIO_FIXED) ? MST_CORE : ~last_q;
    else if (req == 2'b10)  sel = MST_DMA;
    else                    sel = MST_CORE;

    s_req  = ~rst_i & req[sel] & ~fifo_full;
    accept = s_req & s_gnt_i;
    s_bus  = (sel == MST_DMA) ? m1_bus : m0_bus;

    if (hold_act) hold_d = accept ? ST_IDLE : ST_HOLD;
    else          hold_d = (s_req & ~s_gnt_i) ? ST_HOLD : ST_IDLE;
    sel_d  = sel;
    last_d = accept ? sel : last_q;

    rsp_vld = ~rst_i & s_rvalid_i & ~fifo_empty;
    stray   = s_rvalid_i & (fifo_cnt == '0);
    err_d   = err_q | stray;
  end

  id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .pop_i   (s_rvalid_i),
    .din_i   (sel),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q <= ST_IDLE;
      sel_q  <= MST_CORE;
      last_q <= MST_DMA;
      err_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      sel_q  <= sel_d;
      last_q <= last_d;
      err_q  <= err_d;
    end
  end

  assign s_req_o     = s_req;
  assign s_we_o      = s_bus.we;
  assign s_be_o      = s_bus.be;
  assign s_addr_o    = s_bus.addr;
  assign s_wdata_o   = s_bus.wdata;
  assign m0_gnt_o    = accept & (sel == MST_CORE);
  assign m1_gnt_o    = accept & (sel == MST_DMA);
  assign m0_rvalid_o = rsp_vld & (head == MST_CORE);
  assign m1_rvalid_o = rsp_vld & (head == MST_DMA);
  assign m0_rdata_o  = m0_rvalid_o ? s_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : '0;
  assign err_o       = err_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share one stimulus stream.
module tb_data_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        s_gnt, s_rvalid;
  logic [31:0] s_rdata;

  logic        r_m0_gnt, r_m0_rvalid, r_m1_gnt, r_m1_rvalid, r_s_req, r_s_we, r_err;
  logic [31:0] r_m0_rdata, r_m1_rdata, r_s_addr, r_s_wdata;
  logic [3:0]  r_s_be;
  logic        f_m0_gnt, f_m0_rvalid, f_m1_gnt, f_m1_rvalid, f_s_req, f_s_we, f_err;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_s_addr, f_s_wdata;
  logic [3:0]  f_s_be;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_bus_arbiter #(.MAX_OUTSTANDING(2), .PRIO_MODE(0)) dut_rr (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(r_m0_gnt), .m0_rvalid_o(r_m0_rvalid), .m0_rdata_o(r_m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(r_m1_gnt), .m1_rvalid_o(r_m1_rvalid), .m1_rdata_o(r_m1_rdata),
    .s_req_o(r_s_req), .s_we_o(r_s_we), .s_be_o(r_s_be), .s_addr_o(r_s_addr), .s_wdata_o(r_s_wdata),
    .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .err_o(r_err)
  );

  data_bus_arbiter #(.MAX_OUTSTANDING(2), .PRIO_MODE(1)) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(f_m0_gnt), .m0_rvalid_o(f_m0_rvalid), .m0_rdata_o(f_m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(f_m1_gnt), .m1_rvalid_o(f_m1_rvalid), .m1_rdata_o(f_m1_rdata),
    .s_req_o(f_s_req), .s_we_o(f_s_we), .s_be_o(f_s_be), .s_addr_o(f_s_addr), .s_wdata_o(f_s_wdata),
    .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .err_o(f_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, then let combinational paths settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_m0(input logic r, input logic [31:0] a);
    m0_req = r; m0_addr = a;
  endtask

  task automatic set_m1(input logic r, input logic [31:0] a);
    m1_req = r; m1_addr = a;
  endtask

  task automatic set_s(input logic g, input logic v, input logic [31:0] d);
    s_gnt = g; s_rvalid = v; s_rdata = d;
  endtask

  initial begin
    rst = 1'b1;
    m0_we = 1'b0; m0_be = 4'hF; m0_wdata = 32'h0;
    m1_we = 1'b0; m1_be = 4'h3; m1_wdata = 32'h55;
    set_m0(1'b1, 32'h10); set_m1(1'b0, 32'h0); set_s(1'b1, 1'b1, 32'h0);
    settle();
    chk("rst_s_req",     32'(r_s_req), 32'd0);
    chk("rst_m0_gnt",    32'(r_m0_gnt), 32'd0);
    chk("rst_m0_rvalid", 32'(r_m0_rvalid), 32'd0);
    tick();
    set_m0(1'b0, 32'h0); set_s(1'b0, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    settle();
    chk("idle_s_req", 32'(r_s_req), 32'd0);
    chk("idle_err",   32'(r_err), 32'd0);

    // Single master read
    set_m0(1'b1, 32'h10); set_s(1'b1, 1'b0, 32'h0);
    settle();
    chk("t1_m0_gnt", 32'(r_m0_gnt), 32'd1);
    chk("t1_s_addr", r_s_addr, 32'h10);
    chk("t1_m1_gnt", 32'(r_m1_gnt), 32'd0);
    tick();
    set_m0(1'b0, 32'h0); set_s(1'b0, 1'b1, 32'hDEAD_BEEF);
    settle();
    chk("t1_m0_rvalid", 32'(r_m0_rvalid), 32'd1);
    chk("t1_m0_rdata",  r_m0_rdata, 32'hDEAD_BEEF);
    chk("t1_m1_rvalid", 32'(r_m1_rvalid), 32'd0);
    chk("t1_m1_rdata",  r_m1_rdata, 32'h0);
    tick();

    // Reset pulse restores the master-0 tie preference
    set_s(1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Contention: round-robin vs fixed priority
    m1_we = 1'b1;
    set_m0(1'b1, 32'h100); set_m1(1'b1, 32'h200); set_s(1'b1, 1'b0, 32'h0);
    settle();
    chk("rr0_s_addr", r_s_addr, 32'h100);
    chk("rr0_s_we",   32'(r_s_we), 32'd0);
    chk("rr0_m0_gnt", 32'(r_m0_gnt), 32'd1);
    chk("fp0_m0_gnt", 32'(f_m0_gnt), 32'd1);
    chk("fp0_m1_gnt", 32'(f_m1_gnt), 32'd0);
    tick();
    set_s(1'b1, 1'b1, 32'h11);
    settle();
    chk("rr1_s_addr",    r_s_addr, 32'h200);
    chk("rr1_s_we",      32'(r_s_we), 32'd1);
    chk("rr1_s_be",      32'(r_s_be), 32'h3);
    chk("rr1_s_wdata",   r_s_wdata, 32'h55);
    chk("rr1_m1_gnt",    32'(r_m1_gnt), 32'd1);
    chk("rr1_m0_rdata",  r_m0_rdata, 32'h11);
    chk("fp1_s_addr",    f_s_addr, 32'h100);
    chk("fp1_m1_gnt",    32'(f_m1_gnt), 32'd0);
    chk("fp1_m0_rvalid", 32'(f_m0_rvalid), 32'd1);
    tick();
    set_s(1'b1, 1'b1, 32'h22);
    settle();
    chk("rr2_s_addr",    r_s_addr, 32'h100);
    chk("rr2_m1_rvalid", 32'(r_m1_rvalid), 32'd1);
    chk("rr2_m1_rdata",  r_m1_rdata, 32'h22);
    chk("rr2_m0_rdata",  r_m0_rdata, 32'h0);
    chk("fp2_m1_gnt",    32'(f_m1_gnt), 32'd0);
    chk("fp2_m0_gnt",    32'(f_m0_gnt), 32'd1);
    tick();
    set_s(1'b1, 1'b1, 32'h33);
    settle();
    chk("rr3_s_addr",    r_s_addr, 32'h200);
    chk("rr3_m0_rvalid", 32'(r_m0_rvalid), 32'd1);
    chk("fp3_m0_gnt",    32'(f_m0_gnt), 32'd1);
    chk("fp3_m1_gnt",    32'(f_m1_gnt), 32'd0);
    tick();
    m1_we = 1'b0;
    set_m0(1'b0, 32'h0); set_m1(1'b0, 32'h0); set_s(1'b0, 1'b1, 32'h44);
    settle();
    chk("rr4_m1_rdata",  r_m1_rdata, 32'h44);
    chk("fp4_m0_rvalid", 32'(f_m0_rvalid), 32'd1);
    tick();

    // Stalled master 1 keeps the bus even against a higher-priority master 0
    set_m1(1'b1, 32'h300); set_s(1'b0, 1'b0, 32'h0);
    settle();
    chk("h0_s_req",  32'(r_s_req), 32'd1);
    chk("h0_s_addr", r_s_addr, 32'h300);
    tick();
    set_m0(1'b1, 32'h100);
    for (int i = 1; i < 3; i++) begin
      settle();
      chk("h_stall_rr_addr", r_s_addr, 32'h300);
      chk("h_stall_fp_addr", f_s_addr, 32'h300);
      chk("h_stall_m0_gnt",  32'(f_m0_gnt), 32'd0);
      tick();
    end
    set_s(1'b1, 1'b0, 32'h0);
    settle();
    chk("h3_m1_gnt", 32'(r_m1_gnt), 32'd1);
    chk("h3_fp_m1",  32'(f_m1_gnt), 32'd1);
    chk("h3_m0_gnt", 32'(r_m0_gnt), 32'd0);
    tick();
    set_m1(1'b0, 32'h0);
    settle();
    chk("h4_s_addr", r_s_addr, 32'h100);
    chk("h4_m0_gnt", 32'(r_m0_gnt), 32'd1);
    tick();
    set_m0(1'b0, 32'h0); set_s(1'b0, 1'b1, 32'hA);
    settle();
    chk("h5_m1_rvalid", 32'(r_m1_rvalid), 32'd1);
    tick();
    set_s(1'b0, 1'b1, 32'hB);
    settle();
    chk("h6_m0_rdata", r_m0_rdata, 32'hB);
    tick();

    // Two outstanding fill the FIFO; the pop cycle still blocks
    set_m0(1'b1, 32'h400); set_s(1'b1, 1'b0, 32'h0);
    settle(); chk("f0_s_req", 32'(r_s_req), 32'd1); tick();
    settle(); chk("f1_s_req", 32'(r_s_req), 32'd1); tick();
    settle(); chk("f2_s_req", 32'(r_s_req), 32'd0); chk("f2_m0_gnt", 32'(r_m0_gnt), 32'd0); tick();
    settle(); chk("f3_s_req", 32'(r_s_req), 32'd0); tick();
    set_s(1'b1, 1'b1, 32'h4);
    settle();
    chk("f4_s_req",     32'(r_s_req), 32'd0);
    chk("f4_m0_rvalid", 32'(r_m0_rvalid), 32'd1);
    tick();
    set_s(1'b1, 1'b0, 32'h0);
    settle();
    chk("f5_s_req",  32'(r_s_req), 32'd1);
    chk("f5_m0_gnt", 32'(r_m0_gnt), 32'd1);
    chk("f5_fp_gnt", 32'(f_m0_gnt), 32'd1);
    tick();
    set_m0(1'b0, 32'h0); set_s(1'b0, 1'b1, 32'h5);
    settle(); chk("f6_m0_rvalid", 32'(r_m0_rvalid), 32'd1); tick();
    settle(); chk("f7_m0_rvalid", 32'(r_m0_rvalid), 32'd1); chk("f7_err", 32'(r_err), 32'd0); tick();

    // Stray response with nothing outstanding
    settle();
    chk("s0_m0_rvalid", 32'(r_m0_rvalid), 32'd0);
    chk("s0_m1_rvalid", 32'(r_m1_rvalid), 32'd0);
    tick();
    set_s(1'b0, 1'b0, 32'h0);
    settle();
    chk("s1_err",    32'(r_err), 32'd1);
    chk("s1_fp_err", 32'(f_err), 32'd1);
    tick();

    // Reset with a transaction in flight discards its ID
    set_m0(1'b1, 32'h500); set_s(1'b1, 1'b0, 32'h0);
    tick();
    rst = 1'b1;
    settle();
    chk("r0_s_req",  32'(r_s_req), 32'd0);
    chk("r0_m0_gnt", 32'(r_m0_gnt), 32'd0);
    tick();
    rst = 1'b0;
    set_m0(1'b0, 32'h0); set_s(1'b0, 1'b0, 32'h0);
    settle();
    chk("r1_err", 32'(r_err), 32'd0);
    tick();
    set_s(1'b0, 1'b1, 32'h6);
    settle();
    chk("r2_m0_rvalid", 32'(r_m0_rvalid), 32'd0);
    tick();
    set_m0(1'b1, 32'h700); set_m1(1'b1, 32'h800); set_s(1'b1, 1'b0, 32'h0);
    settle();
    chk("r3_err",    32'(r_err), 32'd1);
    chk("r3_s_addr", r_s_addr, 32'h700);
    chk("r3_m0_gnt", 32'(r_m0_gnt), 32'd1);
    chk("r3_m1_gnt", 32'(r_m1_gnt), 32'd0);
    tick();
    set_m0(1'b0, 32'h0); set_m1(1'b0, 32'h0); set_s(1'b0, 1'b0, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
